// File: rtl/jtlb_access_arbiter_if.sv
// Bundle between the I/D/M requesters, the joint TLB port and the arbiter.
//   I side : iReq/iSeg/iOfs in, iAck/iHit/iAdr out
//   D side : dReq/dSeg/dOfs in, dAck/dHit/dAdr out
//   M side : mReq/mOp/mSeg/mOfs/mData in, mAck/mHit out
//   TLB    : tlbValid/tlbOp/tlbSeg/tlbOfs/tlbData out, tlbDone/tlbHit/tlbAdr in
//   status : busy, tmoErr
// slave is the arbiter's view; master is the view of the surrounding logic.
interface jtlb_access_arbiter_if #(
    parameter int unsigned WORD_LENGTH = 32
) ();
    logic                   iReq;
    logic [WORD_LENGTH-1:0] iSeg;
    logic [WORD_LENGTH-1:0] iOfs;
    logic                   iAck;
    logic                   iHit;
    logic [WORD_LENGTH-1:0] iAdr;

    logic                   dReq;
    logic [WORD_LENGTH-1:0] dSeg;
    logic [WORD_LENGTH-1:0] dOfs;
    logic                   dAck;
    logic                   dHit;
    logic [WORD_LENGTH-1:0] dAdr;

    logic                   mReq;
    logic [1:0]             mOp;
    logic [WORD_LENGTH-1:0] mSeg;
    logic [WORD_LENGTH-1:0] mOfs;
    logic [WORD_LENGTH-1:0] mData;
    logic                   mAck;
    logic                   mHit;

    logic                   tlbValid;
    logic [1:0]             tlbOp;
    logic [WORD_LENGTH-1:0] tlbSeg;
    logic [WORD_LENGTH-1:0] tlbOfs;
    logic [WORD_LENGTH-1:0] tlbData;
    logic                   tlbDone;
    logic                   tlbHit;
    logic [WORD_LENGTH-1:0] tlbAdr;

    logic                   busy;
    logic                   tmoErr;

    modport slave (
        input  iReq, iSeg, iOfs,
        output iAck, iHit, iAdr,
        input  dReq, dSeg, dOfs,
        output dAck, dHit, dAdr,
        input  mReq, mOp, mSeg, mOfs, mData,
        output mAck, mHit,
        output tlbValid, tlbOp, tlbSeg, tlbOfs, tlbData,
        input  tlbDone, tlbHit, tlbAdr,
        output busy, tmoErr
    );

    modport master (
        output iReq, iSeg, iOfs,
        input  iAck, iHit, iAdr,
        output dReq, dSeg, dOfs,
        input  dAck, dHit, dAdr,
        output mReq, mOp, mSeg, mOfs, mData,
        input  mAck, mHit,
        input  tlbValid, tlbOp, tlbSeg, tlbOfs, tlbData,
        output tlbDone, tlbHit, tlbAdr,
        input  busy, tmoErr
    );
endinterface

// File: rtl/jtlb_access_arbiter.sv
// Shares the joint TLB port between instruction fetch (I), data access (D)
// and TLB management (M), one operation in flight at a time.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : requester handshakes, TLB operation port, busy/tmoErr status
// M has priority; I and D alternate when both request. Every output is a flop.
module jtlb_access_arbiter #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    jtlb_access_arbiter_if.slave  bus
);
    localparam int unsigned    CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_PURGE  = 2'b10;

    localparam logic RR_I = 1'b0;
    localparam logic RR_D = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_M} owner_e;

    state_e                 state_q,     state_d;
    owner_e                 owner_q,     owner_d;
    logic                   rr_last_q,   rr_last_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   tlb_valid_q, tlb_valid_d;
    logic [1:0]             tlb_op_q,    tlb_op_d;
    logic [WORD_LENGTH-1:0] tlb_seg_q,   tlb_seg_d;
    logic [WORD_LENGTH-1:0] tlb_ofs_q,   tlb_ofs_d;
    logic [WORD_LENGTH-1:0] tlb_data_q,  tlb_data_d;
    logic                   i_ack_q,     i_ack_d;
    logic                   i_hit_q,     i_hit_d;
    logic [WORD_LENGTH-1:0] i_adr_q,     i_adr_d;
    logic                   d_ack_q,     d_ack_d;
    logic                   d_hit_q,     d_hit_d;
    logic [WORD_LENGTH-1:0] d_adr_q,     d_adr_d;
    logic                   m_ack_q,     m_ack_d;
    logic                   m_hit_q,     m_hit_d;
    logic                   busy_q,      busy_d;
    logic                   tmo_err_q,   tmo_err_d;

    // Completion of the current operation, either by tlbDone or by timeout
    logic                   fin;
    logic                   fin_hit;
    logic [WORD_LENGTH-1:0] fin_adr;

    // Next-state, operand capture and result routing
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        cnt_d      = cnt_q;
        tlb_op_d   = tlb_op_q;
        tlb_seg_d  = tlb_seg_q;
        tlb_ofs_d  = tlb_ofs_q;
        tlb_data_d = tlb_data_q;
        tmo_err_d  = 1'b0;
        fin        = 1'b0;
        fin_hit    = 1'b0;
        fin_adr    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.mReq) begin
                    owner_d    = OWN_M;
                    // Reserved encoding 11 behaves as a purge
                    tlb_op_d   = (bus.mOp == 2'b00) ? OP_LOOKUP :
                                 (bus.mOp == 2'b01) ? OP_INSERT : OP_PURGE;
                    tlb_seg_d  = bus.mSeg;
                    tlb_ofs_d  = bus.mOfs;
                    tlb_data_d = bus.mData;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end else if (bus.iReq && (!bus.dReq || rr_last_q == RR_D)) begin
                    owner_d    = OWN_I;
                    rr_last_d  = RR_I;
                    tlb_op_d   = OP_LOOKUP;
                    tlb_seg_d  = bus.iSeg;
                    tlb_ofs_d  = bus.iOfs;
                    tlb_data_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end else if (bus.dReq) begin
                    owner_d    = OWN_D;
                    rr_last_d  = RR_D;
                    tlb_op_d   = OP_LOOKUP;
                    tlb_seg_d  = bus.dSeg;
                    tlb_ofs_d  = bus.dOfs;
                    tlb_data_d = '0;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving on the timeout edge takes precedence
                if (bus.tlbDone) begin
                    fin     = 1'b1;
                    fin_hit = bus.tlbHit;
                    fin_adr = bus.tlbAdr;
                end else if (cnt_q == CNT_LAST) begin
                    fin       = 1'b1;
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fin) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        i_ack_d = fin && (owner_q == OWN_I);
        i_hit_d = i_ack_d && fin_hit;
        i_adr_d = i_ack_d ? fin_adr : '0;
        d_ack_d = fin && (owner_q == OWN_D);
        d_hit_d = d_ack_d && fin_hit;
        d_adr_d = d_ack_d ? fin_adr : '0;
        m_ack_d = fin && (owner_q == OWN_M);
        // Inserts report no hit
        m_hit_d = m_ack_d && fin_hit && (tlb_op_q != OP_INSERT);

        tlb_valid_d = (state_d == ST_WAIT);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            rr_last_q   <= RR_D;
            cnt_q       <= '0;
            tlb_valid_q <= 1'b0;
            tlb_op_q    <= '0;
            tlb_seg_q   <= '0;
            tlb_ofs_q   <= '0;
            tlb_data_q  <= '0;
            i_ack_q     <= 1'b0;
            i_hit_q     <= 1'b0;
            i_adr_q     <= '0;
            d_ack_q     <= 1'b0;
            d_hit_q     <= 1'b0;
            d_adr_q     <= '0;
            m_ack_q     <= 1'b0;
            m_hit_q     <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            cnt_q       <= cnt_d;
            tlb_valid_q <= tlb_valid_d;
            tlb_op_q    <= tlb_op_d;
            tlb_seg_q   <= tlb_seg_d;
            tlb_ofs_q   <= tlb_ofs_d;
            tlb_data_q  <= tlb_data_d;
            i_ack_q     <= i_ack_d;
            i_hit_q     <= i_hit_d;
            i_adr_q     <= i_adr_d;
            d_ack_q     <= d_ack_d;
            d_hit_q     <= d_hit_d;
            d_adr_q     <= d_adr_d;
            m_ack_q     <= m_ack_d;
            m_hit_q     <= m_hit_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign bus.tlbValid = tlb_valid_q;
    assign bus.tlbOp    = tlb_op_q;
    assign bus.tlbSeg   = tlb_seg_q;
    assign bus.tlbOfs   = tlb_ofs_q;
    assign bus.tlbData  = tlb_data_q;
    assign bus.iAck     = i_ack_q;
    assign bus.iHit     = i_hit_q;
    assign bus.iAdr     = i_adr_q;
    assign bus.dAck     = d_ack_q;
    assign bus.dHit     = d_hit_q;
    assign bus.dAdr     = d_adr_q;
    assign bus.mAck     = m_ack_q;
    assign bus.mHit     = m_hit_q;
    assign bus.busy     = busy_q;
    assign bus.tmoErr   = tmo_err_q;
endmodule

// File: tb/tb_jtlb_access_arbiter.sv
// Scoreboard bench for jtlb_access_arbiter: stimulus queues expected TLB
// operations and expected acks; a TLB model and an ack monitor pop and compare.
module tb_jtlb_access_arbiter;
    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 16;

    typedef logic [2*W+6:0] obs_t;  // {iAck,iHit,iAdr,dAck,dHit,dAdr,mAck,mHit,tmoErr}
    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] seg;
        logic [W-1:0] ofs;
        logic [W-1:0] data;
        int           delay;   // WAIT cycle index carrying tlbDone; 0 = never
        logic         hit;
        logic [W-1:0] adr;
    } tlb_rsp_t;

    logic clk;
    logic rst;

    jtlb_access_arbiter_if #(.WORD_LENGTH(W)) bus ();

    jtlb_access_arbiter #(.WORD_LENGTH(W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t     exp_q[$];
    tlb_rsp_t tlb_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int i_issued = 0, i_acked = 0;
    int d_issued = 0, d_acked = 0;
    int m_issued = 0, m_acked = 0;

    // A requester holds req until each issued transaction is acked
    assign bus.iReq = (i_issued != i_acked);
    assign bus.dReq = (d_issued != d_acked);
    assign bus.mReq = (m_issued != m_acked);

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic obs_t mk(input int who, input logic hit, input logic [W-1:0] adr, input logic tmo);
        obs_t o;
        case (who)
            1:       o = {1'b1, hit, adr, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0, tmo};
            2:       o = {1'b0, 1'b0, {W{1'b0}}, 1'b1, hit, adr, 1'b0, 1'b0, tmo};
            default: o = {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0, {W{1'b0}}, 1'b1, hit, tmo};
        endcase
        return o;
    endfunction

    task automatic add_op(input logic [1:0] op, input logic [W-1:0] seg, input logic [W-1:0] ofs,
                          input logic [W-1:0] data, input int delay, input logic hit, input logic [W-1:0] adr);
        tlb_rsp_t r;
        r = '{op: op, seg: seg, ofs: ofs, data: data, delay: delay, hit: hit, adr: adr};
        tlb_q.push_back(r);
    endtask

    task automatic expect_ack(input int who, input logic hit, input logic [W-1:0] adr, input logic tmo);
        exp_q.push_back(mk(who, hit, adr, tmo));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Requester side: count acks so req drops in the ack cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.iAck && i_acked != i_issued) i_acked++;
            if (bus.dAck && d_acked != d_issued) d_acked++;
            if (bus.mAck && m_acked != m_issued) m_acked++;
        end
    end

    // TLB model: checks each presented operation and answers after its delay
    initial begin : tlb_model
        tlb_rsp_t cur;
        int wcnt;
        wcnt        = 0;
        cur         = '{op: 2'b00, seg: '0, ofs: '0, data: '0, delay: 1, hit: 1'b0, adr: '0};
        bus.tlbDone = 1'b0;
        bus.tlbHit  = 1'b0;
        bus.tlbAdr  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.tlbValid) begin
                wcnt        = 0;
                bus.tlbDone = 1'b0;
                bus.tlbHit  = 1'b0;
                bus.tlbAdr  = '0;
            end else begin
                if (wcnt == 0) begin
                    if (tlb_q.size() == 0) begin
                        check("tlb_unexpected_op", 128'(bus.tlbValid), 128'(0));
                        cur = '{op: bus.tlbOp, seg: bus.tlbSeg, ofs: bus.tlbOfs, data: bus.tlbData,
                                delay: 1, hit: 1'b0, adr: '0};
                    end else begin
                        cur = tlb_q.pop_front();
                    end
                end
                check("tlb_operands", {bus.tlbOp, bus.tlbSeg, bus.tlbOfs, bus.tlbData},
                      {cur.op, cur.seg, cur.ofs, cur.data});
                wcnt++;
                bus.tlbHit  = cur.hit;
                bus.tlbAdr  = cur.adr;
                bus.tlbDone = (cur.delay != 0) && (wcnt == cur.delay);
            end
        end
    end

    // Ack monitor: every ack must match the next expected response, else all zero
    initial begin : monitor
        obs_t o;
        forever begin
            @(negedge clk);
            o = {bus.iAck, bus.iHit, bus.iAdr, bus.dAck, bus.dHit, bus.dAdr, bus.mAck, bus.mHit, bus.tmoErr};
            if (bus.iAck || bus.dAck || bus.mAck) begin
                if (exp_q.size() == 0) check("unexpected_ack", 128'(o), 128'(0));
                else                   check("ack_result", 128'(o), 128'(exp_q.pop_front()));
            end else begin
                check("idle_results", 128'(o), 128'(0));
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || tlb_q.size() != 0 || bus.busy ||
                bus.iReq || bus.dReq || bus.mReq) && k < budget) begin
            tick();
            k++;
        end
        check(name, 128'(k >= budget), 128'(0));
    endtask

    task automatic do_reset();
        tick();
        rst      = 1'b0;
        i_issued = i_acked;
        d_issued = d_acked;
        m_issued = m_acked;
        #1;
        check("reset_ctrl", {bus.tlbValid, bus.busy, bus.tmoErr, bus.iAck, bus.dAck, bus.mAck, bus.tlbOp}, 0);
        check("reset_operands", {bus.tlbSeg, bus.tlbOfs, bus.tlbData}, 0);
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus.iSeg  = '0;
        bus.iOfs  = '0;
        bus.dSeg  = '0;
        bus.dOfs  = '0;
        bus.mOp   = 2'b00;
        bus.mSeg  = '0;
        bus.mOfs  = '0;
        bus.mData = '0;
        #1 rst = 1'b0;
        do_reset();

        // 1: single I lookup, done in the second WAIT cycle
        bus.iSeg = 32'h10;
        bus.iOfs = 32'h1234;
        add_op(2'b00, 32'h10, 32'h1234, 32'h0, 2, 1'b1, 32'h00ABC234);
        expect_ack(1, 1'b1, 32'h00ABC234, 1'b0);
        tick();
        i_issued++;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t1_timing", {bus.tlbValid, bus.iAck, bus.busy}, {(c <= 2), (c == 3), (c <= 3)});
        end
        wait_idle("t1_complete", 50);

        // 2: I and D held together after reset -> I, D, I, D
        do_reset();
        bus.iSeg = 32'h20;
        bus.iOfs = 32'h100;
        bus.dSeg = 32'h30;
        bus.dOfs = 32'h200;
        add_op(2'b00, 32'h20, 32'h100, 32'h0, 1, 1'b1, 32'hA0000001);
        add_op(2'b00, 32'h30, 32'h200, 32'h0, 2, 1'b0, 32'hA0000002);
        add_op(2'b00, 32'h20, 32'h100, 32'h0, 3, 1'b1, 32'hA0000003);
        add_op(2'b00, 32'h30, 32'h200, 32'h0, 1, 1'b1, 32'hA0000004);
        expect_ack(1, 1'b1, 32'hA0000001, 1'b0);
        expect_ack(2, 1'b0, 32'hA0000002, 1'b0);
        expect_ack(1, 1'b1, 32'hA0000003, 1'b0);
        expect_ack(2, 1'b1, 32'hA0000004, 1'b0);
        tick();
        i_issued += 2;
        d_issued += 2;
        wait_idle("t2_complete", 100);

        // 3: M insert beats a simultaneous I request; insert reports no hit
        bus.mOp   = 2'b01;
        bus.mSeg  = 32'h40;
        bus.mOfs  = 32'h300;
        bus.mData = 32'hCAFE0001;
        bus.iSeg  = 32'h50;
        bus.iOfs  = 32'h400;
        add_op(2'b01, 32'h40, 32'h300, 32'hCAFE0001, 1, 1'b1, 32'hDEAD0000);
        add_op(2'b00, 32'h50, 32'h400, 32'h0, 2, 1'b0, 32'h11112222);
        expect_ack(3, 1'b0, 32'h0, 1'b0);
        expect_ack(1, 1'b0, 32'h11112222, 1'b0);
        tick();
        m_issued++;
        i_issued++;
        wait_idle("t3_complete", 50);

        // 4: D lookup never completes -> forced ack after TMO WAIT cycles
        bus.dSeg = 32'h60;
        bus.dOfs = 32'h500;
        add_op(2'b00, 32'h60, 32'h500, 32'h0, 0, 1'b1, 32'hFFFFFFFF);
        expect_ack(2, 1'b0, 32'h0, 1'b1);
        tick();
        d_issued++;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check("t4_timeout", {bus.tlbValid, bus.dAck, bus.tmoErr, bus.busy},
                  {(c <= 16), (c == 17), (c == 17), (c <= 17)});
        end
        wait_idle("t4_complete", 20);

        // 5: reset during WAIT aborts the I lookup without an ack
        bus.iSeg = 32'h70;
        bus.iOfs = 32'h600;
        add_op(2'b00, 32'h70, 32'h600, 32'h0, 0, 1'b1, 32'h0);
        tick();
        i_issued++;
        repeat (3) tick();
        check("t5_in_wait", 128'(bus.tlbValid), 128'(1));
        #1;
        rst      = 1'b0;
        i_issued = i_acked;
        #1;
        check("t5_abort", {bus.tlbValid, bus.busy, bus.iAck}, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (10) tick();
        check("t5_quiet", {bus.busy, bus.tlbValid}, 0);
        bus.dSeg = 32'h80;
        bus.dOfs = 32'h700;
        add_op(2'b00, 32'h80, 32'h700, 32'h0, 3, 1'b1, 32'h00C0FFEE);
        expect_ack(2, 1'b1, 32'h00C0FFEE, 1'b0);
        tick();
        d_issued++;
        wait_idle("t5_complete", 50);

        // 6: probe whose done lands on the timeout edge -> done wins
        bus.mOp   = 2'b00;
        bus.mSeg  = 32'h90;
        bus.mOfs  = 32'h800;
        bus.mData = 32'h0;
        add_op(2'b00, 32'h90, 32'h800, 32'h0, 16, 1'b1, 32'h00001234);
        expect_ack(3, 1'b1, 32'h0, 1'b0);
        tick();
        m_issued++;
        wait_idle("t6_complete", 50);

        // 7: reserved mOp=11 issues a purge and reports its hit
        bus.mOp  = 2'b11;
        bus.mSeg = 32'hA0;
        bus.mOfs = 32'h900;
        add_op(2'b10, 32'hA0, 32'h900, 32'h0, 1, 1'b1, 32'h0);
        expect_ack(3, 1'b1, 32'h0, 1'b0);
        tick();
        m_issued++;
        wait_idle("t7_complete", 50);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
